uart_tx_buffered: RTL and testbench

Buffered 8N1 UART transmitter.
- Accepts bytes from the processor-side TX handshake (UART_TXD / TX_EN / TX_STATUS).
- Queues them in a small FIFO and serialises them LSB-first on UART_TX.
- Outbound counterpart to the board's UART receive path. Lets the core post bursts of bytes without polling per bit.

---
 rtl/uart_tx_buffered_if.sv | 9 +
 rtl/uart_tx_buffered.sv | 129 ++++++++++++
 tb/tb_uart_tx_buffered.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_buffered_if.sv
// rtl/uart_tx_buffered_if.sv - processor-side byte handshake into the buffered UART transmitter
interface uart_tx_buffered_if;
    logic [7:0] UART_TXD;
    logic       TX_EN;
    logic       TX_STATUS;

    modport master (output UART_TXD, output TX_EN, input TX_STATUS);
    modport slave  (input UART_TXD, input TX_EN, output TX_STATUS);
endinterface

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered 8N1 UART transmitter; `UART_TX_PARITY_EN adds an even-parity bit
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_AW      = 3
) (
    input  logic               sysclk,
    input  logic               reset,
    uart_tx_buffered_if.slave  tx,
    output logic               UART_TX,
    output logic               tx_busy,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]    BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW+1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state;
    logic [7:0]           mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic [7:0]           shift;
    logic [2:0]           bit_idx;
    logic [CW-1:0]        baud_cnt;
    logic                 tx_status_r;

    logic                 full, empty, baud_wrap, push, pop, line_next;
    logic [FIFO_AW:0]     count_next;

    // Full test uses the pre-edge count, so a pop on the same edge never makes room.
    always_comb begin
        full      = (fifo_count == FULL_COUNT);
        empty     = (fifo_count == '0);
        baud_wrap = (baud_cnt == BAUD_LAST);
        push      = tx.TX_EN && !full;
        pop       = !empty && ((state == S_IDLE) || (state == S_STOP && baud_wrap));
        case ({push, pop})
            2'b10:   count_next = fifo_count + 1'b1;
            2'b01:   count_next = fifo_count - 1'b1;
            default: count_next = fifo_count;
        endcase
        case (state)
            S_START:  line_next = 1'b0;
            S_DATA:   line_next = shift[bit_idx];
            S_PARITY: line_next = ^shift;
            default:  line_next = 1'b1;
        endcase
    end

    assign tx.TX_STATUS = tx_status_r;
    assign tx_busy      = (state != S_IDLE) || !empty;

    always_ff @(posedge sysclk) begin
        if (reset && push)
            mem[wr_ptr] <= tx.UART_TXD;
    end

    // The line register lags the state by one cycle, keeping every bit exactly CLKS_PER_BIT wide.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            tx_status_r <= 1'b1;
            overflow    <= 1'b0;
            UART_TX     <= 1'b1;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shift       <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (tx.TX_EN && full)
                overflow <= 1'b1;
            fifo_count  <= count_next;
            tx_status_r <= (count_next != FULL_COUNT);
            UART_TX     <= line_next;
            baud_cnt    <= baud_wrap ? '0 : baud_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (baud_wrap) begin
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_wrap) begin
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_wrap)
                        state <= S_STOP;
                end
                S_STOP: begin
                    if (baud_wrap) begin
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - scoreboard bench for uart_tx_buffered with a serial-line frame decoder
module tb_uart_tx_buffered;
    localparam int CPB = 4;
    localparam int AW  = 3;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic          sysclk = 1'b0;
    logic          reset  = 1'b0;
    logic          UART_TX;
    logic          tx_busy;
    logic [AW:0]   fifo_count;
    logic          overflow;
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    logic [7:0]    exp_q[$];
    int            starts[$];

    uart_tx_buffered_if bus ();

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .tx         (bus),
        .UART_TX    (UART_TX),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b);
        bus.UART_TXD = b;
        bus.TX_EN    = 1'b1;
        @(posedge sysclk);
        #1;
        bus.TX_EN    = 1'b0;
        bus.UART_TXD = 8'hFF;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge sysclk);
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (tx_busy && n < budget) begin
            @(posedge sysclk);
            #1;
            n++;
        end
        check("idle_timeout", tx_busy, 1'b0);
        idle(2);
    endtask

    // Decoder: find each falling edge on the line and sample every bit in its middle.
    initial begin : monitor
        logic       prev_line;
        logic [10:0] bits;
        logic       aborted;
        logic [7:0] want;
        prev_line = 1'b1;
        forever begin
            @(negedge sysclk);
            if (reset && prev_line === 1'b1 && UART_TX === 1'b0) begin
                starts.push_back(cyc);
                aborted = 1'b0;
                bits    = '0;
                for (int m = 1; m <= 4 * (FRAME_BITS - 1) + 1; m++) begin
                    @(negedge sysclk);
                    if (!reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (m >= 5 && ((m - 1) % 4) == 0)
                        bits[(m - 5) / 4] = UART_TX;
                end
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", {24'd0, bits[7:0]}, 32'hDEAD);
                    end else begin
                        want = exp_q.pop_front();
                        check("frame_data", {24'd0, bits[7:0]}, {24'd0, want});
`ifdef UART_TX_PARITY_EN
                        check("frame_parity", bits[8], ^want);
`endif
                        check("frame_stop", bits[FRAME_BITS-2], 1'b1);
                    end
                end
            end
            prev_line = UART_TX;
        end
    end

    initial begin : stim
        logic [7:0] burst [9];
        int lows;
        bus.TX_EN    = 1'b0;
        bus.UART_TXD = 8'h00;
        reset        = 1'b0;
        idle(3);
        reset = 1'b1;
        check("rst_uart_tx", UART_TX, 1'b1);
        check("rst_tx_status", bus.TX_STATUS, 1'b1);
        check("rst_tx_busy", tx_busy, 1'b0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_overflow", overflow, 1'b0);
        idle(2);

        // single 0x55 frame, latency and busy timing
        exp_q.push_back(8'h55);
        wr(8'h55);
        check("t1_line_e0", UART_TX, 1'b1);
        idle(1);
        check("t1_line_e1", UART_TX, 1'b1);
        idle(1);
        check("t1_line_e2_start", UART_TX, 1'b0);
        idle(FRAME_CYC - 2);
        check("t1_busy_before_end", tx_busy, 1'b1);
        idle(1);
        check("t1_busy_after_end", tx_busy, 1'b0);
        check("t1_line_idle", UART_TX, 1'b1);
        wait_idle(200);

        // back-to-back frames
        starts.delete();
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h0F);
        wr(8'hA3);
        check("t2_count_e0", fifo_count, 1);
        wr(8'h0F);
        check("t2_count_peak", fifo_count, 1);
        wait_idle(300);
        check("t2_frames", starts.size(), 2);
        if (starts.size() == 2)
            check("t2_gap", starts[1] - starts[0], FRAME_CYC);

        // write on the same edge as a pop with the FIFO full
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66, 8'h77, 8'h88, 8'h99};
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(burst[i]);
            wr(burst[i]);
        end
        check("t5_full_count", fifo_count, 8);
        check("t5_full_status", bus.TX_STATUS, 1'b0);
        idle(FRAME_CYC - 8);
        check("t5_pre_count", fifo_count, 8);
        check("t5_pre_ovf", overflow, 1'b0);
        wr(8'hEE);
        check("t5_post_count", fifo_count, 7);
        check("t5_post_ovf", overflow, 1'b1);
        check("t5_post_status", bus.TX_STATUS, 1'b1);
        wait_idle(1000);

        pulse_reset();
        check("rst2_overflow", overflow, 1'b0);

        // burst during DATA with overflow on the ninth byte
        burst = '{8'hC1, 8'h02, 8'hF3, 8'h84, 8'h45, 8'hB6, 8'h27, 8'hD8, 8'h6B};
        exp_q.push_back(8'h3C);
        wr(8'h3C);
        idle(12);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(burst[i]);
            wr(burst[i]);
        end
        check("t3_status_full", bus.TX_STATUS, 1'b0);
        check("t3_count_full", fifo_count, 8);
        check("t3_ovf_before", overflow, 1'b0);
        wr(burst[8]);
        check("t3_ovf_after", overflow, 1'b1);
        check("t3_count_after", fifo_count, 8);
        wait_idle(1000);
        check("t3_ovf_sticky", overflow, 1'b1);

        // reset mid-frame
        wr(8'h96);
        wr(8'h69);
        idle(12);
        pulse_reset();
        check("t4_line", UART_TX, 1'b1);
        check("t4_count", fifo_count, 0);
        check("t4_ovf", overflow, 1'b0);
        check("t4_busy", tx_busy, 1'b0);
        check("t4_status", bus.TX_STATUS, 1'b1);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            idle(1);
            if (UART_TX !== 1'b1) lows++;
        end
        check("t4_no_frames", lows, 0);

`ifdef UART_TX_PARITY_EN
        exp_q.push_back(8'h07);
        wr(8'h07);
        wait_idle(200);
`endif

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
